// File: rtl/mini_micro_core.sv
// mini_micro_core
//   Multi-cycle 16-bit-instruction microprocessor with an 8 x WORD_SIZE register
//   file, a program memory loaded through a write port, and a valid/ready
//   result port that stalls the core until each OUT value is accepted.
//
//   Optional feature macro: MINI_MICRO_MUL_EN
//     defined   -> opcode C is MUL (rd = low WORD_SIZE bits of ra * rb)
//     undefined -> opcode C is illegal and no multiplier is built
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-low reset
//   start        one-cycle pulse, begins execution at PC 0 (ignored while busy)
//   prog_we      program memory write enable (honoured only in IDLE/HALTED)
//   prog_addr    program memory write address
//   prog_wdata   instruction word to write
//   output_data  value emitted by OUT, held until the next OUT
//   out_valid    output_data is valid
//   out_ready    consumer accepts output_data
//   busy         core is in FETCH, EXEC or OUT_WAIT
//   halted       HALT or an illegal opcode was reached
//   illegal      sticky illegal-opcode flag, cleared by start
//   pc_out       current program counter
module mini_micro_core #(
  parameter int WORD_SIZE  = 32,
  parameter int IMEM_DEPTH = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          prog_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] prog_addr,
  input  logic [15:0]                   prog_wdata,
  output logic [WORD_SIZE-1:0]          output_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          busy,
  output logic                          halted,
  output logic                          illegal,
  output logic [$clog2(IMEM_DEPTH)-1:0] pc_out
);

  localparam int AW = $clog2(IMEM_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_OUT_WAIT,
    S_HALTED
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_ADD  = 4'h2,
    OP_SUB  = 4'h3,
    OP_AND  = 4'h4,
    OP_OR   = 4'h5,
    OP_XOR  = 4'h6,
    OP_SHL  = 4'h7,
    OP_BEQZ = 4'h8,
    OP_JMP  = 4'h9,
    OP_OUT  = 4'hA,
    OP_HALT = 4'hB,
    OP_MUL  = 4'hC
  } opcode_t;

  logic [15:0]          imem [IMEM_DEPTH];
  logic [WORD_SIZE-1:0] regs [8];

  state_t               state;
  logic [AW-1:0]        pc;
  logic [15:0]          ir;

  // Instruction fields
  opcode_t              op;
  logic [2:0]           rd;
  logic [2:0]           ra_idx;
  logic [2:0]           rb_idx;
  logic [5:0]           imm6;
  logic signed [5:0]    imm_s;
  logic [WORD_SIZE-1:0] ra_val;
  logic [WORD_SIZE-1:0] rb_val;

  // Execute-stage decode results
  logic                 wr_en;
  logic [WORD_SIZE-1:0] wr_val;
  logic [AW-1:0]        pc_next;
  logic                 ex_out;
  logic                 ex_halt;
  logic                 ex_illegal;

  logic                 idle_like;

  assign op     = opcode_t'(ir[15:12]);
  assign rd     = ir[11:9];
  assign ra_idx = ir[8:6];
  assign rb_idx = ir[5:3];
  assign imm6   = ir[5:0];
  assign imm_s  = ir[5:0];

  // R0 always reads as zero regardless of storage contents
  assign ra_val = (ra_idx == 3'd0) ? '0 : regs[ra_idx];
  assign rb_val = (rb_idx == 3'd0) ? '0 : regs[rb_idx];

  assign idle_like = (state == S_IDLE) || (state == S_HALTED);
  assign busy      = !idle_like;
  assign pc_out    = pc;

  // Size casts of the signed immediate sign-extend when widening and truncate
  // when narrowing, so branch offsets wrap modulo IMEM_DEPTH for any AW.
  always_comb begin
    wr_en      = 1'b0;
    wr_val     = '0;
    pc_next    = pc + AW'(1);
    ex_out     = 1'b0;
    ex_halt    = 1'b0;
    ex_illegal = 1'b0;
    case (op)
      OP_NOP:  ;
      OP_LDI:  begin wr_en = 1'b1; wr_val = WORD_SIZE'(imm_s);        end
      OP_ADD:  begin wr_en = 1'b1; wr_val = ra_val + rb_val;          end
      OP_SUB:  begin wr_en = 1'b1; wr_val = ra_val - rb_val;          end
      OP_AND:  begin wr_en = 1'b1; wr_val = ra_val & rb_val;          end
      OP_OR:   begin wr_en = 1'b1; wr_val = ra_val | rb_val;          end
      OP_XOR:  begin wr_en = 1'b1; wr_val = ra_val ^ rb_val;          end
      OP_SHL:  begin wr_en = 1'b1; wr_val = ra_val << imm6[4:0];      end
      OP_BEQZ: if (ra_val == '0) pc_next = pc + AW'(imm_s);
      OP_JMP:  pc_next = AW'(imm6);
      OP_OUT:  ex_out = 1'b1;
      OP_HALT: begin ex_halt = 1'b1; pc_next = pc; end
`ifdef MINI_MICRO_MUL_EN
      OP_MUL:  begin wr_en = 1'b1; wr_val = ra_val * rb_val;          end
`endif
      default: begin ex_illegal = 1'b1; pc_next = pc; end
    endcase
  end

  // Program memory: not reset, writable only while the core is stopped
  always_ff @(posedge clk) begin
    if (prog_we && idle_like) begin
      imem[prog_addr] <= prog_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      pc          <= '0;
      ir          <= '0;
      regs        <= '{default: '0};
      output_data <= '0;
      out_valid   <= 1'b0;
      halted      <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_HALTED: begin
          if (start) begin
            state   <= S_FETCH;
            pc      <= '0;
            halted  <= 1'b0;
            illegal <= 1'b0;
          end
        end
        S_FETCH: begin
          ir    <= imem[pc];
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (wr_en && (rd != 3'd0)) begin
            regs[rd] <= wr_val;
          end
          pc <= pc_next;
          if (ex_out) begin
            output_data <= ra_val;
            out_valid   <= 1'b1;
            state       <= S_OUT_WAIT;
          end else if (ex_halt || ex_illegal) begin
            state  <= S_HALTED;
            halted <= 1'b1;
            if (ex_illegal) illegal <= 1'b1;
          end else begin
            state <= S_FETCH;
          end
        end
        S_OUT_WAIT: begin
          // out_valid is always high here, so ready alone completes the handshake
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mini_micro_core.sv
module tb_mini_micro_core;

  localparam int WS    = 32;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clk;
  logic          rst;
  logic          start;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [15:0]   prog_wdata;
  logic [WS-1:0] output_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          halted;
  logic          illegal;
  logic [AW-1:0] pc_out;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [WS-1:0] outq[$];
  int            valid_cycles;

  mini_micro_core #(
    .WORD_SIZE (WS),
    .IMEM_DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_wdata (prog_wdata),
    .output_data(output_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .halted     (halted),
    .illegal    (illegal),
    .pc_out     (pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                      input logic [2:0] ra, input logic [5:0] low);
    return {op, rd, ra, low};
  endfunction

  task automatic load_word(input logic [AW-1:0] a, input logic [15:0] w);
    prog_we    = 1'b1;
    prog_addr  = a;
    prog_wdata = w;
    @(negedge clk);
    prog_we    = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Steps one cycle at a time; halt_cyc is the number of edges after the start
  // edge at which halted was first seen, or -1 when the budget runs out.
  task automatic run_prog(input int max_cycles, output int halt_cyc);
    halt_cyc = -1;
    outq.delete();
    valid_cycles = 0;
    for (int i = 1; i <= max_cycles; i++) begin
      @(negedge clk);
      if (out_valid) begin
        valid_cycles++;
        if (out_ready) outq.push_back(output_data);
      end
      if (halted) begin
        halt_cyc = i;
        break;
      end
    end
  endtask

  task automatic wait_valid(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (output_data !== '0) begin n_fail++; $display("FAIL reset_data: got %0h want 0", output_data); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", halted); end
    n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b want 0", illegal); end
    n_checks++; if (pc_out !== '0) begin n_fail++; $display("FAIL reset_pc: got %0d want 0", pc_out); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int hc;
    load_word(0, enc(4'h1, 3'd1, 3'd0, 6'd5));          // LDI R1,5
    load_word(1, enc(4'h1, 3'd2, 3'd0, 6'b111101));     // LDI R2,-3
    load_word(2, enc(4'h2, 3'd3, 3'd1, {3'd2, 3'd0}));  // ADD R3,R1,R2
    load_word(3, enc(4'hA, 3'd0, 3'd3, 6'd0));          // OUT R3
    load_word(4, enc(4'hB, 3'd0, 3'd0, 6'd0));          // HALT
    out_ready = 1'b1;
    pulse_start();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_rise: got %b want 1", busy); end
    run_prog(40, hc);
    n_checks++; if (hc !== 11) begin n_fail++; $display("FAIL basic_halt_cycle: got %0d want 11", hc); end
    n_checks++; if (valid_cycles !== 1) begin n_fail++; $display("FAIL basic_valid_pulses: got %0d want 1", valid_cycles); end
    n_checks++; if (outq.size() != 1 || outq[0] !== 32'd2) begin n_fail++; $display("FAIL basic_output: got %0d values (first %0h) want one value 2", outq.size(), output_data); end
    n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL basic_illegal: got %b want 0", illegal); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_fall: got %b want 0", busy); end
    n_checks++; if (pc_out !== 6'd4) begin n_fail++; $display("FAIL basic_halt_pc: got %0d want 4", pc_out); end
  endtask

  task automatic test_out_stall();
    int hc;
    bit ok;
    load_word(0, enc(4'h1, 3'd1, 3'd0, 6'd9));          // LDI R1,9
    load_word(1, enc(4'hA, 3'd0, 3'd1, 6'd0));          // OUT R1
    load_word(2, enc(4'hB, 3'd0, 3'd0, 6'd0));          // HALT
    out_ready = 1'b0;
    pulse_start();
    wait_valid(20, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL stall_valid_seen: got %b want 1", ok); end
    for (int j = 0; j < 6; j++) begin
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid_hold[%0d]: got %b want 1", j, out_valid); end
      n_checks++; if (output_data !== 32'd9) begin n_fail++; $display("FAIL stall_data_hold[%0d]: got %0h want 9", j, output_data); end
      n_checks++; if (pc_out !== 6'd2) begin n_fail++; $display("FAIL stall_pc_hold[%0d]: got %0d want 2", j, pc_out); end
      if (j == 5) out_ready = 1'b1;
      @(negedge clk);
    end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_valid_drop: got %b want 0", out_valid); end
    n_checks++; if (output_data !== 32'd9) begin n_fail++; $display("FAIL stall_data_keep: got %0h want 9", output_data); end
    run_prog(20, hc);
    n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL stall_halt: got %b want 1", halted); end
  endtask

  task automatic test_countdown();
    int hc;
    load_word(0, enc(4'h1, 3'd1, 3'd0, 6'd3));          // LDI R1,3
    load_word(1, enc(4'h1, 3'd2, 3'd0, 6'b111111));     // LDI R2,-1
    load_word(2, enc(4'hA, 3'd0, 3'd1, 6'd0));          // OUT R1
    load_word(3, enc(4'h2, 3'd1, 3'd1, {3'd2, 3'd0}));  // ADD R1,R1,R2
    load_word(4, enc(4'h8, 3'd0, 3'd1, 6'd2));          // BEQZ R1,+2
    load_word(5, enc(4'h9, 3'd0, 3'd0, 6'd2));          // JMP 2
    load_word(6, enc(4'hB, 3'd0, 3'd0, 6'd0));          // HALT
    out_ready = 1'b1;
    pulse_start();
    run_prog(200, hc);
    n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL count_halt: got %b want 1", halted); end
    n_checks++; if (outq.size() != 3) begin n_fail++; $display("FAIL count_num_out: got %0d want 3", outq.size()); end
    n_checks++; if (outq.size() != 3 || outq[0] !== 32'd3 || outq[1] !== 32'd2 || outq[2] !== 32'd1) begin
      n_fail++; $display("FAIL count_values: got %0d values want 3,2,1", outq.size());
    end
    n_checks++; if (pc_out !== 6'd6) begin n_fail++; $display("FAIL count_halt_pc: got %0d want 6", pc_out); end
    n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL count_illegal: got %b want 0", illegal); end
  endtask

  task automatic test_illegal();
    int hc;
    load_word(0, enc(4'h1, 3'd1, 3'd0, 6'd1));          // LDI R1,1
    load_word(1, 16'hF000);                             // opcode F
    out_ready = 1'b1;
    pulse_start();
    run_prog(20, hc);
    n_checks++; if (hc !== 4) begin n_fail++; $display("FAIL illegal_halt_cycle: got %0d want 4", hc); end
    n_checks++; if (illegal !== 1'b1) begin n_fail++; $display("FAIL illegal_flag: got %b want 1", illegal); end
    pulse_start();
    n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL illegal_cleared: got %b want 0", illegal); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL illegal_halt_cleared: got %b want 0", halted); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL illegal_restart_busy: got %b want 1", busy); end
    run_prog(20, hc);
    n_checks++; if (illegal !== 1'b1) begin n_fail++; $display("FAIL illegal_again: got %b want 1", illegal); end
  endtask

  task automatic test_mul();
    int hc;
    load_word(0, enc(4'h1, 3'd1, 3'd0, 6'd7));          // LDI R1,7
    load_word(1, enc(4'h1, 3'd2, 3'd0, 6'd6));          // LDI R2,6
    load_word(2, enc(4'hC, 3'd3, 3'd1, {3'd2, 3'd0}));  // MUL R3,R1,R2
    load_word(3, enc(4'hA, 3'd0, 3'd3, 6'd0));          // OUT R3
    load_word(4, enc(4'hB, 3'd0, 3'd0, 6'd0));          // HALT
    out_ready = 1'b1;
    pulse_start();
    run_prog(40, hc);
    n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL mul_halt: got %b want 1", halted); end
`ifdef MINI_MICRO_MUL_EN
    n_checks++; if (outq.size() != 1 || outq[0] !== 32'd42) begin n_fail++; $display("FAIL mul_result: got %0d values (data %0d) want one value 42", outq.size(), output_data); end
    n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL mul_illegal: got %b want 0", illegal); end
`else
    n_checks++; if (illegal !== 1'b1) begin n_fail++; $display("FAIL mul_illegal: got %b want 1", illegal); end
    n_checks++; if (outq.size() != 0) begin n_fail++; $display("FAIL mul_no_output: got %0d values want 0", outq.size()); end
`endif
  endtask

  task automatic test_busy_ignores();
    int hc;
    bit ok;
    load_word(0, enc(4'h1, 3'd1, 3'd0, 6'd1));          // LDI R1,1
    load_word(1, enc(4'hA, 3'd0, 3'd1, 6'd0));          // OUT R1
    load_word(2, enc(4'hB, 3'd0, 3'd0, 6'd0));          // HALT
    out_ready = 1'b0;
    pulse_start();
    wait_valid(20, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL busy_valid_seen: got %b want 1", ok); end
    // Both a program write and a start arrive while stalled in OUT_WAIT
    prog_we    = 1'b1;
    prog_addr  = 6'd2;
    prog_wdata = 16'hF000;
    start      = 1'b1;
    @(negedge clk);
    prog_we = 1'b0;
    start   = 1'b0;
    n_checks++; if (pc_out !== 6'd2) begin n_fail++; $display("FAIL busy_start_pc: got %0d want 2", pc_out); end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL busy_still_valid: got %b want 1", out_valid); end
    out_ready = 1'b1;
    run_prog(20, hc);
    n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL busy_halt: got %b want 1", halted); end
    n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL busy_write_ignored: got %b want 0", illegal); end
    n_checks++; if (pc_out !== 6'd2) begin n_fail++; $display("FAIL busy_halt_pc: got %0d want 2", pc_out); end
  endtask

  task automatic test_reset_mid();
    int hc;
    bit ok;
    load_word(0, enc(4'h1, 3'd1, 3'd0, 6'd5));          // LDI R1,5
    load_word(1, enc(4'hA, 3'd0, 3'd1, 6'd0));          // OUT R1
    load_word(2, enc(4'hB, 3'd0, 3'd0, 6'd0));          // HALT
    out_ready = 1'b0;
    pulse_start();
    wait_valid(20, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rmid_valid_seen: got %b want 1", ok); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b want 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", busy); end
    n_checks++; if (pc_out !== '0) begin n_fail++; $display("FAIL rmid_pc: got %0d want 0", pc_out); end
    n_checks++; if (output_data !== '0) begin n_fail++; $display("FAIL rmid_data: got %0h want 0", output_data); end
    rst = 1'b1;
    @(negedge clk);
    // R1 must have been cleared by the reset
    load_word(0, enc(4'hA, 3'd0, 3'd1, 6'd0));          // OUT R1
    load_word(1, enc(4'hB, 3'd0, 3'd0, 6'd0));          // HALT
    out_ready = 1'b1;
    pulse_start();
    run_prog(20, hc);
    n_checks++; if (outq.size() != 1 || outq[0] !== '0) begin n_fail++; $display("FAIL rmid_reg_cleared: got %0d values (data %0h) want one value 0", outq.size(), output_data); end
  endtask

  initial begin
    rst        = 1'b0;
    start      = 1'b0;
    prog_we    = 1'b0;
    prog_addr  = '0;
    prog_wdata = '0;
    out_ready  = 1'b0;
    test_reset();
    test_basic();
    test_out_stall();
    test_countdown();
    test_illegal();
    test_mul();
    test_busy_ignores();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mini_micro_core.md
# mini_micro_core

Parametrised multi-cycle microprocessor core: the next generation of the team's `Microprocessor`. It runs 16-bit instructions from an internal program memory loaded over a write port, against an 8-entry register file of `WORD_SIZE`-bit registers. Results leave through a valid/ready output port that stalls the core until they are accepted. It sits between the bench or host, which loads the program and pulses `start`, and any downstream consumer of `output_data`.

## Interface
- `WORD_SIZE`, 32: datapath and register width, ≥ 8.
- `IMEM_DEPTH`, 64: program memory depth in 16-bit words, a power of 2, ≥ 4. `AW = $clog2(IMEM_DEPTH)`.
- `clk` in 1: the only clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle pulse that begins execution at PC 0.
- `prog_we` in 1: program memory write enable.
- `prog_addr` in `AW`: program memory write address.
- `prog_wdata` in 16: instruction word to write.
- `output_data` out `WORD_SIZE`: value emitted by OUT.
- `out_valid` out 1: `output_data` is valid.
- `out_ready` in 1: consumer accepts the value.
- `busy` out 1: core is executing (any state other than IDLE or HALTED).
- `halted` out 1: HALT or an illegal opcode reached.
- `illegal` out 1: sticky, set by an illegal opcode.
- `pc_out` out `AW`: current PC.

## Operation
- Instruction fields: `op`=[15:12], `rd`=[11:9], `ra`=[8:6], `rb`=[5:3], `imm6`=[5:0].
- R0 reads as 0; writes to R0 are discarded.
- Opcodes:
  - 0 NOP.
  - 1 LDI: `rd` = sign-extended `imm6`.
  - 2 ADD: `rd` = `ra` + `rb`.
  - 3 SUB: `rd` = `ra` − `rb`.
  - 4 AND, 5 OR, 6 XOR: bitwise `ra` op `rb` into `rd`.
  - 7 SHL: `rd` = `ra` << `imm6[4:0]`.
  - 8 BEQZ: if `ra`==0, PC = PC + sign-extended `imm6`; otherwise PC+1.
  - 9 JMP: PC = zero-extended `imm6`.
  - A OUT: emit `ra`.
  - B HALT.
  - C MUL: only when the macro is defined (see Configuration).
  - Any other opcode is illegal.
- Arithmetic is modulo 2^`WORD_SIZE`; carries and overflow are dropped.
- All PC arithmetic wraps modulo `IMEM_DEPTH`.
- FSM states: IDLE, FETCH, EXEC, OUT_WAIT, HALTED.
  - IDLE/HALTED → FETCH on `start`: PC←0, `illegal`←0, `halted`←0. Registers are retained.
  - FETCH → EXEC: IR←imem[PC].
  - EXEC → FETCH: writeback and PC update.
  - EXEC → OUT_WAIT on OUT: `output_data`←`ra`, PC←PC+1.
  - EXEC → HALTED on HALT. PC stays on the HALT instruction.
  - EXEC → HALTED on an illegal opcode: `illegal`←1.
  - OUT_WAIT → FETCH when `out_valid` && `out_ready`.
- `prog_we` is honoured only in IDLE or HALTED; it is ignored while `busy`.
- `start` is ignored while `busy`.

## Timing
- Reset values: IDLE; PC=0; all registers 0; `output_data`=0; `out_valid`=0; `busy`=0; `halted`=0; `illegal`=0. Program memory is not cleared.
- Reset asserted mid-operation, including in OUT_WAIT, returns everything to the reset values on the next edge. `out_valid` drops with no handshake.
- `busy` rises the cycle after `start`.
- Each non-OUT instruction takes exactly 2 cycles (FETCH + EXEC). A result written in EXEC is visible to the next instruction's EXEC.
- OUT takes 2 cycles plus the stall:
  - `out_valid` rises the cycle after EXEC.
  - `output_data` holds stable while `out_valid`=1, and keeps its last value afterwards.
  - Completion: `out_ready` high at the entry edge of OUT_WAIT → 1 stall cycle. Each further low cycle adds one.
  - `out_ready` asserted before `out_valid` has no effect.
- `halted` rises the cycle after the HALT/illegal EXEC. `busy` falls in the same cycle.
- A program write takes effect at the edge; a FETCH in the next cycle returns the new word.

## Configuration
- `MINI_MICRO_MUL_EN` defined: opcode C is MUL, `rd` = low `WORD_SIZE` bits of `ra`×`rb`, single-cycle in EXEC.
- Undefined: opcode C is illegal, giving HALTED with `illegal`=1, and no multiplier is synthesised.

## Test plan
- Reset with `rst`=0 for 2 cycles → all outputs at their reset values.
- Load LDI R1,5; LDI R2,−3; ADD R3,R1,R2; OUT R3; HALT; pulse `start`, `out_ready`=1 → `output_data`=2 with one valid pulse; `halted`=1 eleven cycles after `start`; `illegal`=0.
- OUT with `out_ready` held low for 5 cycles → `out_valid` stays high and `output_data` stable for 6 cycles; PC does not advance until the handshake.
- Countdown loop: LDI R1,3; LDI R2,−1; loop {OUT R1; ADD R1,R1,R2; BEQZ R1,+2; JMP loop}; HALT → outputs 3, 2, 1 then halt.
- Opcode F executed → `halted`=1, `illegal`=1; a following `start` clears `illegal`.
- Opcode C with R1=7, R2=6: with `MINI_MICRO_MUL_EN` defined → R3=42; without it → `illegal`=1.
